// File: rtl/hybrid_adder8_struct.sv
// hybrid_adder8_struct: registered 8-bit adder with a hybrid carry chain.
// Carry structure: ripple on bits 1:0, 4-bit lookahead on bits 5:2, ripple on bits 7:6.
// The lookahead block derives c3..c6 directly from c2 so that the long path
// C0 -> c2 -> c6 -> c8 crosses only two ripple cells per outer stage.

// Single-bit full adder built from gates; used for the ripple stages.
module hybrid_adder8_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic g;

  assign p  = a ^ b;
  assign g  = a & b;
  assign s  = p ^ ci;
  assign co = g | (p & ci);

endmodule

// Gate-level 4-bit carry-lookahead generator.
// Every carry is a flat sum of products of g/p terms and the incoming carry,
// with no carry feeding another carry inside the block.
module hybrid_adder8_cla4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       ci,
  output logic [3:0] co
);

  // co[k] is the carry out of local bit k (local bit 0 = adder bit 2).
  assign co[0] = g[0]
               | (p[0] & ci);

  assign co[1] = g[1]
               | (p[1] & g[0])
               | (p[1] & p[0] & ci);

  assign co[2] = g[2]
               | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & ci);

  assign co[3] = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & ci);

endmodule

// Top level: structural carry chain plus the output register.
module hybrid_adder8_struct (
  output logic [7:0] S,
  output logic       C8,
  input  logic [7:0] X,
  input  logic [7:0] Y,
  input  logic       C0,
  input  logic       clk,
  input  logic       rst
);

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned CLA_LO  = 2;
  localparam int unsigned CLA_W   = 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_c;

  // Bit-level generate/propagate terms shared by the lookahead block and sums.
  assign g    = X & Y;
  assign p    = X ^ Y;
  assign c[0] = C0;

  // Stage 1: ripple through bits 1:0.
  hybrid_adder8_fa u_fa0 (
    .a  (X[0]),
    .b  (Y[0]),
    .ci (c[0]),
    .s  (s_c[0]),
    .co (c[1])
  );

  hybrid_adder8_fa u_fa1 (
    .a  (X[1]),
    .b  (Y[1]),
    .ci (c[1]),
    .s  (s_c[1]),
    .co (c[2])
  );

  // Stage 2: lookahead carries c3..c6 from c2; sums are p ^ carry-in per bit.
  hybrid_adder8_cla4 u_cla (
    .g  (g[CLA_LO +: CLA_W]),
    .p  (p[CLA_LO +: CLA_W]),
    .ci (c[CLA_LO]),
    .co (c[CLA_LO+1 +: CLA_W])
  );

  assign s_c[CLA_LO +: CLA_W] = p[CLA_LO +: CLA_W] ^ c[CLA_LO +: CLA_W];

  // Stage 3: ripple through bits 7:6 fed by c6.
  hybrid_adder8_fa u_fa6 (
    .a  (X[6]),
    .b  (Y[6]),
    .ci (c[6]),
    .s  (s_c[6]),
    .co (c[7])
  );

  hybrid_adder8_fa u_fa7 (
    .a  (X[7]),
    .b  (Y[7]),
    .ci (c[7]),
    .s  (s_c[7]),
    .co (c[8])
  );

  // Output register: captures sum and carry-out each cycle, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S  <= '0;
      C8 <= 1'b0;
    end else begin
      S  <= s_c;
      C8 <= c[WIDTH];
    end
  end

endmodule

// File: tb/tb_hybrid_adder8_struct.sv
// tb_hybrid_adder8_struct: directed and randomized checks of the registered adder
// against an arithmetic reference {C8,S} = X + Y + C0.
module tb_hybrid_adder8_struct;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] X   = '0;
  logic [7:0] Y   = '0;
  logic       C0  = 1'b0;
  logic [7:0] S;
  logic       C8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hybrid_adder8_struct dut (
    .S   (S),
    .C8  (C8),
    .X   (X),
    .Y   (Y),
    .C0  (C0),
    .clk (clk),
    .rst (rst)
  );

  // Reference: plain 9-bit unsigned addition.
  function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b, input logic ci);
    return 9'(a) + 9'(b) + 9'(ci);
  endfunction

  task automatic check_out(input string tag, input logic [7:0] exp_s, input logic exp_c);
    checks++;
    assert (S === exp_s) else begin
      errors++;
      $error("FAIL %s S observed %h expected %h", tag, S, exp_s);
    end
    checks++;
    assert (C8 === exp_c) else begin
      errors++;
      $error("FAIL %s C8 observed %b expected %b", tag, C8, exp_c);
    end
  endtask

  // Apply operands, take one rising edge, check the registered result.
  task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] r;
    X  = a;
    Y  = b;
    C0 = ci;
    @(posedge clk);
    #1;
    r = ref_sum(a, b, ci);
    check_out(tag, r[7:0], r[8]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [8:0] r;

    // Reset with maximum operands applied: outputs must stay cleared.
    X  = 8'hFF;
    Y  = 8'hFF;
    C0 = 1'b1;
    #1 rst = 1'b1;
    #1 check_out("reset_async", 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1 check_out("reset_hold", 8'h00, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1 check_out("first_capture", 8'hFF, 1'b1);

    // Directed cases.
    step("basic_60_7f",     8'h60, 8'h7F, 1'b0);
    step("basic_ff_fe",     8'hFF, 8'hFE, 1'b0);
    step("prop_aa_55_c0",   8'hAA, 8'h55, 1'b0);
    step("prop_aa_55_c1",   8'hAA, 8'h55, 1'b1);
    step("cin_08_81_c0",    8'h08, 8'h81, 1'b0);
    step("cin_08_81_c1",    8'h08, 8'h81, 1'b1);
    step("cin_01_00_c1",    8'h01, 8'h00, 1'b1);
    step("upper_gen_f0_88", 8'hF0, 8'h88, 1'b1);
    step("max_ff_ff_c1",    8'hFF, 8'hFF, 1'b1);
    step("zero",            8'h00, 8'h00, 1'b0);
    step("prop_0f_f0_c1",   8'h0F, 8'hF0, 1'b1);
    step("lookahead_3c_04", 8'h3C, 8'h04, 1'b0);

    // Random back-to-back operands, one per cycle.
    for (int i = 0; i < 4000; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      ci = 1'($urandom);
      step("random", a, b, ci);

      // Inputs changing between edges must not disturb the registered result.
      if ((i % 256) == 17) begin
        r  = ref_sum(a, b, ci);
        X  = 8'($urandom);
        Y  = 8'($urandom);
        C0 = 1'($urandom);
        #2 check_out("hold_between_edges", r[7:0], r[8]);
      end

      // Asynchronous reset mid-stream: clear before any clock edge, then recover.
      if (i == 2000) begin
        #2 rst = 1'b1;
        #1 check_out("midstream_async_reset", 8'h00, 1'b0);
        X  = 8'hFF;
        Y  = 8'hFF;
        C0 = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_out("midstream_reset_hold", 8'h00, 1'b0);
        rst = 1'b0;
        step("after_midstream_reset", 8'h12, 8'h34, 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
